writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Drives the integer register file's single write port (write index, write data) from two producers: the execute stage and the load/memory response path.
- Arbitrates between the two with a fairness cap and buffers load responses in a small FIFO.
- Sign/zero-extends and aligns load data.
- Tracks outstanding load destinations in a scoreboard that decode uses for stalls.

Parameters:
- BITSIZE, 32, datapath width; only 32 is supported.
- LOAD_FIFO_DEPTH, 2, load response FIFO entries; power of two, ≥2.
- MAX_LD_BURST, 4, maximum consecutive load writebacks granted while an execute result waits.

Ports:
- clk  in  1  core clock
- rstn_i  in  1  reset, asynchronous, active-low
- ex_valid_i  in  1  execute result valid
- ex_ready_o  out  1  execute result accepted this cycle when high with ex_valid_i
- ex_rd_i  in  5  execute destination register
- ex_data_i  in  32  execute result
- ld_valid_i  in  1  load response valid
- ld_ready_o  out  1  load FIFO can accept
- ld_rd_i  in  5  load destination register
- ld_data_i  in  32  raw aligned memory word
- ld_funct3_i  in  3  load type (RISC-V funct3)
- ld_offset_i  in  2  byte address offset within the word
- ld_issue_i  in  1  a load was issued to memory this cycle
- ld_issue_rd_i  in  5  destination of the issued load
- rf_we_o  out  1  register file write enable
- rf_rd_o  out  5  register file write index
- rf_data_o  out  32  register file write data
- pending_o  out  32  bitmask of registers awaiting load writeback

Behaviour:
- Reset (asynchronous, rstn_i low):
  - rf_we_o=0, rf_rd_o=0, rf_data_o=0, pending_o=0.
  - FIFO empty, burst counter 0.
  - Reset mid-operation discards all buffered loads; no write is issued afterwards for them.
- Load FIFO:
  - ld_ready_o = !full; this does not depend on a same-cycle pop.
  - Push on ld_valid_i && ld_ready_o.
  - Extension is done before the push: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - The byte lane is ld_offset_i. The halfword lane is ld_offset_i[1]; ld_offset_i[0] is ignored for LH/LHU.
  - Any other funct3 stores ld_data_i unchanged.
  - Pointers wrap modulo LOAD_FIFO_DEPTH; an occupancy counter distinguishes full from empty.
  - Simultaneous push and pop keeps occupancy constant.
- Arbitration (per cycle):
  - If the FIFO is non-empty and not (ex_valid_i && burst==MAX_LD_BURST): pop the head, grant the load, ex_ready_o=0.
  - Otherwise: ex_ready_o=1 and the execute result is granted when ex_valid_i.
  - Burst counter increments on each load grant while ex_valid_i is high, saturating at MAX_LD_BURST.
  - Burst counter clears on an ex grant or when ex_valid_i is low.
- Output register: on each edge, rf_we_o <= (grant && rd!=0); rf_rd_o and rf_data_o load the granted rd and data.
  - With no grant, rf_we_o <= 0 and rf_rd_o/rf_data_o hold their values.
  - rd==0 completes its handshake but never asserts rf_we_o.
- Latency:
  - Execute accept at cycle N → rf_we_o high in cycle N+1.
  - Load push at cycle N (empty FIFO, no contention) → pop at N+1 → rf_we_o high in N+2.
- Scoreboard:
  - At the edge, a bit is set on ld_issue_i for ld_issue_rd_i != 0.
  - A bit is cleared at the edge where a load grant for that rd loads the output register.
  - Set and clear of the same rd in the same cycle: set wins.
  - pending_o[0] is always 0.
  - A clear of a non-pending bit is a no-op.

Optional Feature:
- Macro WB_FORWARD_EN.
- When defined, adds outputs fwd_valid_o (1), fwd_rd_o (5) and fwd_data_o (32).
  - These are combinational copies of the current-cycle grant (valid = grant && rd!=0), available one cycle before rf_we_o.
  - Decode bypasses with them instead of stalling on pending_o.
- When undefined, these ports do not exist and no combinational path from inputs to outputs exists other than ex_ready_o.

Test Plan:
- Reset: assert rstn_i low mid-burst with 2 loads buffered → all outputs 0 immediately; after release, no rf_we_o for the discarded loads; pending_o=0.
- Execute path: ex_valid_i=1, rd=5, data=0xDEADBEEF at cycle N, FIFO empty → ex_ready_o=1; cycle N+1: rf_we_o=1, rf_rd_o=5, rf_data_o=0xDEADBEEF.
- Load extension: push LB offset 3 with data 0x80FF_0000 (byte 0x80) → written data 0xFFFFFF80. LHU offset 2 with data 0x8001_0000 → 0x00008001.
- Fairness: FIFO refilled continuously, ex_valid_i held high → ex granted after exactly 4 load writes; ex_ready_o pulses once; the FIFO never overflows (ld_ready_o low when full).
- Scoreboard: ld_issue rd=7 → pending_o[7]=1. The load for rd=7 writes back in the same cycle a new ld_issue rd=7 occurs → pending_o[7] stays 1. rd=0 issue → pending_o unchanged.
- x0 writes: ex rd=0 and load rd=0 → handshakes complete, rf_we_o stays 0 throughout.

Source files
------------

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Drives the integer register file's single write port from two producers:
//   the execute stage and the load response path. Load responses are
//   extended/aligned, buffered in a small FIFO, and normally win arbitration.
//   A burst cap lets a waiting execute result through after MAX_LD_BURST
//   consecutive load writebacks. A scoreboard tracks outstanding load
//   destinations for decode stalls.
//
//   Optional feature macro: WB_FORWARD_EN adds fwd_valid_o/fwd_rd_o/fwd_data_o,
//   a combinational view of the current-cycle grant for decode bypass.
//
// Ports:
//   clk, rstn_i          clock, async active-low reset
//   ex_*                 execute result handshake (valid/ready, rd, data)
//   ld_*                 load response (valid/ready, rd, raw word, funct3, offset)
//   ld_issue_i/_rd_i     load issued to memory this cycle (scoreboard set)
//   rf_we_o/rd_o/data_o  registered register file write port
//   pending_o            registers awaiting load writeback
module writeback_arbiter #(
  parameter int BITSIZE         = 32,
  parameter int LOAD_FIFO_DEPTH = 2,
  parameter int MAX_LD_BURST    = 4
) (
  input  logic               clk,
  input  logic               rstn_i,
  input  logic               ex_valid_i,
  output logic               ex_ready_o,
  input  logic [4:0]         ex_rd_i,
  input  logic [BITSIZE-1:0] ex_data_i,
  input  logic               ld_valid_i,
  output logic               ld_ready_o,
  input  logic [4:0]         ld_rd_i,
  input  logic [BITSIZE-1:0] ld_data_i,
  input  logic [2:0]         ld_funct3_i,
  input  logic [1:0]         ld_offset_i,
  input  logic               ld_issue_i,
  input  logic [4:0]         ld_issue_rd_i,
  output logic               rf_we_o,
  output logic [4:0]         rf_rd_o,
  output logic [BITSIZE-1:0] rf_data_o,
  output logic [31:0]        pending_o
`ifdef WB_FORWARD_EN
  ,
  output logic               fwd_valid_o,
  output logic [4:0]         fwd_rd_o,
  output logic [BITSIZE-1:0] fwd_data_o
`endif
);

  localparam int PW = (LOAD_FIFO_DEPTH > 1) ? $clog2(LOAD_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(LOAD_FIFO_DEPTH + 1);
  localparam int BW = $clog2(MAX_LD_BURST + 1);

  typedef struct packed {
    logic [4:0]         rd;
    logic [BITSIZE-1:0] data;
  } wb_t;

  // load extension / alignment, done before the push
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [BITSIZE-1:0] ld_ext;

  always_comb begin
    ld_byte = ld_data_i[{ld_offset_i, 3'b000} +: 8];
    ld_half = ld_offset_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
    ld_ext  = ld_data_i;
    case (ld_funct3_i)
      3'b000:  ld_ext = {{(BITSIZE-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(BITSIZE-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(BITSIZE-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(BITSIZE-16){1'b0}}, ld_half};
      default: ld_ext = ld_data_i;
    endcase
  end

  // load FIFO
  wb_t            fifo_q [LOAD_FIFO_DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic [CW-1:0]  cnt;
  logic           full, nonempty, push, pop;
  wb_t            head;

  assign full       = (cnt == CW'(LOAD_FIFO_DEPTH));
  assign nonempty   = (cnt != '0);
  assign ld_ready_o = !full;
  assign push       = ld_valid_i && ld_ready_o;
  assign head       = fifo_q[rptr];

  // arbitration: loads win unless an execute result has waited out the cap
  logic [BW-1:0] burst;
  logic          ld_grant, ex_grant, g_valid;
  wb_t           g;

  assign ld_grant   = nonempty && !(ex_valid_i && (burst == BW'(MAX_LD_BURST)));
  assign pop        = ld_grant;
  assign ex_ready_o = !ld_grant;
  assign ex_grant   = ex_ready_o && ex_valid_i;
  assign g_valid    = ld_grant || ex_grant;
  assign g          = ld_grant ? head : wb_t'{rd: ex_rd_i, data: ex_data_i};

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr] <= wb_t'{rd: ld_rd_i, data: ld_ext};
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i)                     burst <= '0;
    else if (!ex_valid_i || ex_grant) burst <= '0;
    else if (ld_grant && burst != BW'(MAX_LD_BURST)) burst <= burst + BW'(1);
  end

  // registered write port; rd/data hold when idle
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rf_we_o   <= 1'b0;
      rf_rd_o   <= '0;
      rf_data_o <= '0;
    end else begin
      rf_we_o <= g_valid && (g.rd != 5'd0);
      if (g_valid) begin
        rf_rd_o   <= g.rd;
        rf_data_o <= g.data;
      end
    end
  end

  // scoreboard: set wins over a same-cycle clear
  logic [31:0] sb_set, sb_clr;
  assign sb_set = (ld_issue_i && ld_issue_rd_i != 5'd0) ? (32'd1 << ld_issue_rd_i) : 32'd0;
  assign sb_clr = ld_grant ? (32'd1 << head.rd) : 32'd0;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) pending_o <= '0;
    else         pending_o <= ((pending_o & ~sb_clr) | sb_set) & ~32'd1;
  end

`ifdef WB_FORWARD_EN
  assign fwd_valid_o = g_valid && (g.rd != 5'd0);
  assign fwd_rd_o    = g.rd;
  assign fwd_data_o  = g.data;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rstn_i;
  logic        ex_valid_i, ex_ready_o;
  logic [4:0]  ex_rd_i;
  logic [31:0] ex_data_i;
  logic        ld_valid_i, ld_ready_o;
  logic [4:0]  ld_rd_i;
  logic [31:0] ld_data_i;
  logic [2:0]  ld_funct3_i;
  logic [1:0]  ld_offset_i;
  logic        ld_issue_i;
  logic [4:0]  ld_issue_rd_i;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;
  logic [31:0] pending_o;

  int checks = 0;
  int failures = 0;

  writeback_arbiter dut (
    .clk(clk), .rstn_i(rstn_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_rd_i(ex_rd_i), .ex_data_i(ex_data_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i),
    .ld_funct3_i(ld_funct3_i), .ld_offset_i(ld_offset_i),
    .ld_issue_i(ld_issue_i), .ld_issue_rd_i(ld_issue_rd_i),
    .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    ex_valid_i = 0; ex_rd_i = 0; ex_data_i = 0;
    ld_valid_i = 0; ld_rd_i = 0; ld_data_i = 0; ld_funct3_i = 3'b010; ld_offset_i = 0;
    ld_issue_i = 0; ld_issue_rd_i = 0;
  endtask

  task automatic test_reset;
    idle();
    rstn_i = 1;
    #2 rstn_i = 0;
    #1;
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", rf_we_o); end
    checks++; if (rf_rd_o !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", rf_rd_o); end
    checks++; if (rf_data_o !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", rf_data_o); end
    checks++; if (pending_o !== 32'd0) begin failures++; $display("FAIL reset_pending got=%h exp=0", pending_o); end
    checks++; if (ld_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready_o); end
    checks++; if (ex_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ex_ready got=%b exp=1", ex_ready_o); end
    tick(); tick();
    rstn_i = 1;
    tick();
  endtask

  task automatic test_execute;
    ex_valid_i = 1; ex_rd_i = 5; ex_data_i = 32'hDEADBEEF;
    #1;
    checks++; if (ex_ready_o !== 1'b1) begin failures++; $display("FAIL ex_ready got=%b exp=1", ex_ready_o); end
    tick();
    ex_valid_i = 0;
    checks++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd5 || rf_data_o !== 32'hDEADBEEF)
      begin failures++; $display("FAIL ex_write got=%b/%0d/%h exp=1/5/deadbeef", rf_we_o, rf_rd_o, rf_data_o); end
    tick();
    checks++; if (rf_we_o !== 1'b0 || rf_rd_o !== 5'd5 || rf_data_o !== 32'hDEADBEEF)
      begin failures++; $display("FAIL ex_hold got=%b/%0d/%h exp=0/5/deadbeef", rf_we_o, rf_rd_o, rf_data_o); end
  endtask

  logic [2:0]  ext_f3  [7] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b010, 3'b011, 3'b001};
  logic [1:0]  ext_off [7] = '{2'd3, 2'd2, 2'd3, 2'd1, 2'd0, 2'd1, 2'd0};
  logic [31:0] ext_in  [7] = '{32'h80FF0000, 32'h80010000, 32'h80010000, 32'h00009A00,
                               32'hCAFEF00D, 32'h12345678, 32'h00007FFF};
  logic [31:0] ext_exp [7] = '{32'hFFFFFF80, 32'h00008001, 32'hFFFF8001, 32'h0000009A,
                               32'hCAFEF00D, 32'h12345678, 32'h00007FFF};

  task automatic test_load_ext;
    for (int i = 0; i < 7; i++) begin
      ld_valid_i = 1; ld_rd_i = 5'(i + 1); ld_funct3_i = ext_f3[i];
      ld_offset_i = ext_off[i]; ld_data_i = ext_in[i];
      #1;
      checks++; if (ld_ready_o !== 1'b1) begin failures++; $display("FAIL ext_ready[%0d] got=%b exp=1", i, ld_ready_o); end
      tick();
      ld_valid_i = 0;
      checks++; if (rf_we_o !== 1'b0) begin failures++; $display("FAIL ext_early[%0d] got=%b exp=0", i, rf_we_o); end
      tick();
      checks++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'(i + 1) || rf_data_o !== ext_exp[i])
        begin failures++; $display("FAIL ext_write[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, rf_we_o, rf_rd_o, rf_data_o, i + 1, ext_exp[i]); end
    end
    ld_funct3_i = 3'b010; ld_offset_i = 0;
  endtask

  logic exv   [10] = '{0,1,1,1,1,1,0,0,0,0};
  logic ldv   [10] = '{1,1,1,1,1,1,1,1,0,0};
  logic exr   [10] = '{1,0,0,0,0,1,0,0,0,1};
  logic ldr   [10] = '{1,1,1,1,1,1,0,1,1,1};
  int   exp_rd[10] = '{0,16,17,18,19,9,20,21,22,0};

  task automatic test_fairness;
    int k = 0;
    int pulses = 0;
    ex_rd_i = 9; ex_data_i = 32'd9; ld_funct3_i = 3'b010;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin
        if (exp_rd[c-1] == 0) begin
          checks++; if (rf_we_o !== 1'b0) begin failures++; $display("FAIL fair_idle[%0d] got=%b exp=0", c - 1, rf_we_o); end
        end else begin
          checks++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'(exp_rd[c-1]) || rf_data_o !== 32'(exp_rd[c-1]))
            begin failures++; $display("FAIL fair_write[%0d] got=%b/%0d/%0d exp=1/%0d", c - 1, rf_we_o, rf_rd_o, rf_data_o, exp_rd[c-1]); end
        end
      end
      if (c == 10) break;
      ex_valid_i = exv[c]; ld_valid_i = ldv[c];
      ld_rd_i = 5'(16 + k); ld_data_i = 32'(16 + k);
      #1;
      checks++; if (ex_ready_o !== exr[c]) begin failures++; $display("FAIL fair_ex_ready[%0d] got=%b exp=%b", c, ex_ready_o, exr[c]); end
      checks++; if (ld_ready_o !== ldr[c]) begin failures++; $display("FAIL fair_ld_ready[%0d] got=%b exp=%b", c, ld_ready_o, ldr[c]); end
      if (ld_valid_i && ld_ready_o) k++;
      if (ex_valid_i && ex_ready_o) pulses++;
      tick();
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL fair_pulses got=%0d exp=1", pulses); end
    checks++; if (k !== 7) begin failures++; $display("FAIL fair_pushes got=%0d exp=7", k); end
    idle();
  endtask

  task automatic test_scoreboard;
    ld_issue_i = 1; ld_issue_rd_i = 7;
    tick();
    ld_issue_i = 0;
    checks++; if (pending_o !== 32'h80) begin failures++; $display("FAIL sb_set got=%h exp=00000080", pending_o); end
    ld_issue_i = 1; ld_issue_rd_i = 0;
    tick();
    ld_issue_i = 0;
    checks++; if (pending_o !== 32'h80) begin failures++; $display("FAIL sb_x0 got=%h exp=00000080", pending_o); end
    ld_valid_i = 1; ld_rd_i = 7; ld_data_i = 32'h77;
    tick();
    ld_valid_i = 0; ld_issue_i = 1; ld_issue_rd_i = 7;
    tick();
    ld_issue_i = 0;
    checks++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd7 || pending_o !== 32'h80)
      begin failures++; $display("FAIL sb_set_wins got=%b/%0d/%h exp=1/7/00000080", rf_we_o, rf_rd_o, pending_o); end
    ld_valid_i = 1; ld_rd_i = 7; ld_data_i = 32'h78;
    tick();
    ld_valid_i = 0;
    tick();
    checks++; if (rf_we_o !== 1'b1 || rf_data_o !== 32'h78 || pending_o !== 32'h0)
      begin failures++; $display("FAIL sb_clear got=%b/%h/%h exp=1/78/0", rf_we_o, rf_data_o, pending_o); end
  endtask

  task automatic test_x0;
    ex_valid_i = 1; ex_rd_i = 0; ex_data_i = 32'h55;
    #1;
    checks++; if (ex_ready_o !== 1'b1) begin failures++; $display("FAIL x0_ex_ready got=%b exp=1", ex_ready_o); end
    tick();
    ex_valid_i = 0;
    checks++; if (rf_we_o !== 1'b0 || rf_rd_o !== 5'd0 || rf_data_o !== 32'h55)
      begin failures++; $display("FAIL x0_ex got=%b/%0d/%h exp=0/0/55", rf_we_o, rf_rd_o, rf_data_o); end
    ld_valid_i = 1; ld_rd_i = 0; ld_data_i = 32'h66;
    tick();
    ld_valid_i = 0;
    #1;
    checks++; if (ex_ready_o !== 1'b0 || rf_we_o !== 1'b0)
      begin failures++; $display("FAIL x0_ld_pop got=%b/%b exp=0/0", ex_ready_o, rf_we_o); end
    tick();
    checks++; if (rf_we_o !== 1'b0 || rf_data_o !== 32'h66)
      begin failures++; $display("FAIL x0_ld got=%b/%h exp=0/66", rf_we_o, rf_data_o); end
    tick();
    checks++; if (rf_we_o !== 1'b0 || ex_ready_o !== 1'b1)
      begin failures++; $display("FAIL x0_drained got=%b/%b exp=0/1", rf_we_o, ex_ready_o); end
  endtask

  task automatic test_reset_mid;
    ld_funct3_i = 3'b010; ld_rd_i = 12; ld_data_i = 32'd12;
    ex_rd_i = 4; ex_data_i = 32'd4;
    for (int c = 0; c < 6; c++) begin
      ld_valid_i = 1; ex_valid_i = (c != 0);
      ld_issue_i = (c == 0); ld_issue_rd_i = 25;
      tick();
    end
    idle();
    checks++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd4 || pending_o !== 32'h0200_0000)
      begin failures++; $display("FAIL mid_pre got=%b/%0d/%h exp=1/4/02000000", rf_we_o, rf_rd_o, pending_o); end
    checks++; if (ld_ready_o !== 1'b0) begin failures++; $display("FAIL mid_full got=%b exp=0", ld_ready_o); end
    rstn_i = 0;
    #1;
    checks++; if (rf_we_o !== 1'b0 || rf_rd_o !== 5'd0 || rf_data_o !== 32'd0 || pending_o !== 32'd0)
      begin failures++; $display("FAIL mid_reset got=%b/%0d/%h/%h exp=0/0/0/0", rf_we_o, rf_rd_o, rf_data_o, pending_o); end
    tick(); tick();
    rstn_i = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (rf_we_o !== 1'b0 || ex_ready_o !== 1'b1 || pending_o !== 32'd0)
        begin failures++; $display("FAIL mid_after[%0d] got=%b/%b/%h exp=0/1/0", c, rf_we_o, ex_ready_o, pending_o); end
    end
  endtask

  initial begin
    test_reset();
    test_execute();
    test_load_ext();
    test_fairness();
    test_scoreboard();
    test_x0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
